// File: rtl/uart_rx_edge_sampler.sv
// UART RX oversampling timebase, 3-sample majority bit recovery and LSB-first deserializer.
// Latency: SAMPLED_BIT valid one cycle after the third sample; no backpressure, all strobes come from the RX FSM.
module uart_rx_edge_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [5:0] PRESCALE,
    input  logic       COUNTER_EN,
    input  logic       COUNT_RST,
    input  logic       SAMPLER_EN,
    input  logic       DESERIALIZER_EN,
    output logic [4:0] EDGE_COUNT,
    output logic [3:0] BIT_COUNT,
    output logic       SAMPLED_BIT,
    output logic [7:0] P_DATA
);

    logic [4:0] last_edge;
    logic [4:0] first_sample;
    logic       edge_wrap;
    logic       sample_0;
    logic       sample_1;
    logic       vote;

    // Unsupported ratios fall back to 8x oversampling.
    always_comb begin
        last_edge    = 5'd7;
        first_sample = 5'd2;
        case (PRESCALE)
            6'd16: begin
                last_edge    = 5'd15;
                first_sample = 5'd6;
            end
            6'd32: begin
                last_edge    = 5'd31;
                first_sample = 5'd14;
            end
            default: begin
                last_edge    = 5'd7;
                first_sample = 5'd2;
            end
        endcase
    end

    // ">=" also recovers an edge count left out of range by a prescale change.
    assign edge_wrap = (EDGE_COUNT >= last_edge);
    assign vote      = (sample_0 & sample_1) | (sample_0 & RX_IN) | (sample_1 & RX_IN);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            EDGE_COUNT <= 5'd0;
            BIT_COUNT  <= 4'd0;
        end else if (!COUNT_RST) begin
            EDGE_COUNT <= 5'd0;
            BIT_COUNT  <= 4'd0;
        end else if (COUNTER_EN) begin
            if (edge_wrap) begin
                EDGE_COUNT <= 5'd0;
                BIT_COUNT  <= BIT_COUNT + 4'd1;
            end else begin
                EDGE_COUNT <= EDGE_COUNT + 5'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sample_0    <= 1'b1;
            sample_1    <= 1'b1;
            SAMPLED_BIT <= 1'b1;
        end else if (COUNTER_EN) begin
            if (EDGE_COUNT == first_sample)
                sample_0 <= RX_IN;
            if (EDGE_COUNT == first_sample + 5'd1)
                sample_1 <= RX_IN;
            if (SAMPLER_EN && (EDGE_COUNT == first_sample + 5'd2))
                SAMPLED_BIT <= vote;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            P_DATA <= 8'h00;
        else if (DESERIALIZER_EN)
            P_DATA <= {SAMPLED_BIT, P_DATA[7:1]};
    end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// Directed bench for uart_rx_edge_sampler: counters, majority vote, deserializer, reset and hold.
module tb_uart_rx_edge_sampler;

    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       COUNTER_EN;
    logic       COUNT_RST;
    logic       SAMPLER_EN;
    logic       DESERIALIZER_EN;
    logic [4:0] EDGE_COUNT;
    logic [3:0] BIT_COUNT;
    logic       SAMPLED_BIT;
    logic [7:0] P_DATA;

    int checks = 0;
    int errors = 0;

    uart_rx_edge_sampler dut (
        .CLK             (CLK),
        .RST             (RST),
        .RX_IN           (RX_IN),
        .PRESCALE        (PRESCALE),
        .COUNTER_EN      (COUNTER_EN),
        .COUNT_RST       (COUNT_RST),
        .SAMPLER_EN      (SAMPLER_EN),
        .DESERIALIZER_EN (DESERIALIZER_EN),
        .EDGE_COUNT      (EDGE_COUNT),
        .BIT_COUNT       (BIT_COUNT),
        .SAMPLED_BIT     (SAMPLED_BIT),
        .P_DATA          (P_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_counters();
        COUNT_RST = 1'b0;
        tick(1);
        COUNT_RST = 1'b1;
    endtask

    logic [9:0] frame;

    initial begin
        RST             = 1'b0;
        RX_IN           = 1'b1;
        PRESCALE        = 6'd16;
        COUNTER_EN      = 1'b0;
        COUNT_RST       = 1'b1;
        SAMPLER_EN      = 1'b0;
        DESERIALIZER_EN = 1'b0;
        tick(3);
        chk("rst_edge", EDGE_COUNT, 0);
        chk("rst_bit", BIT_COUNT, 0);
        chk("rst_sampled", SAMPLED_BIT, 1);
        chk("rst_pdata", P_DATA, 8'h00);
        RST = 1'b1;

        // Put non-reset values in P_DATA and SAMPLED_BIT before the mid-count reset.
        DESERIALIZER_EN = 1'b1;
        tick(1);
        DESERIALIZER_EN = 1'b0;
        chk("shift_idle_one", P_DATA, 8'h80);
        RX_IN      = 1'b0;
        SAMPLER_EN = 1'b1;
        COUNTER_EN = 1'b1;
        tick(57);
        chk("midcount_edge", EDGE_COUNT, 9);
        chk("midcount_bit", BIT_COUNT, 3);
        chk("midcount_sampled", SAMPLED_BIT, 0);
        #2 RST = 1'b0;
        #1;
        chk("async_rst_edge", EDGE_COUNT, 0);
        chk("async_rst_bit", BIT_COUNT, 0);
        chk("async_rst_sampled", SAMPLED_BIT, 1);
        chk("async_rst_pdata", P_DATA, 8'h00);
        #1 RST = 1'b1;
        RX_IN = 1'b1;
        tick(1);
        chk("resume_edge1", EDGE_COUNT, 1);
        tick(1);
        chk("resume_edge2", EDGE_COUNT, 2);
        chk("resume_bit", BIT_COUNT, 0);

        // Wrap and bit count at 8x.
        PRESCALE   = 6'd8;
        COUNTER_EN = 1'b0;
        SAMPLER_EN = 1'b0;
        clear_counters();
        chk("clear_edge", EDGE_COUNT, 0);
        chk("clear_bit", BIT_COUNT, 0);
        COUNTER_EN = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            tick(1);
            chk("wrap_edge", EDGE_COUNT, k % 8);
            chk("wrap_bit", BIT_COUNT, k / 8);
        end
        tick(48);
        chk("bit_wrap16_bit", BIT_COUNT, 0);
        chk("bit_wrap16_edge", EDGE_COUNT, 0);
        tick(11);
        chk("pre_clear_bit", BIT_COUNT, 1);
        chk("pre_clear_edge", EDGE_COUNT, 3);
        COUNT_RST = 1'b0;
        tick(1);
        COUNT_RST = 1'b1;
        chk("clear_over_en_edge", EDGE_COUNT, 0);
        chk("clear_over_en_bit", BIT_COUNT, 0);

        // Majority vote at 16x: samples at edges 6,7,8, result visible at edge 9.
        PRESCALE   = 6'd16;
        COUNTER_EN = 1'b0;
        clear_counters();
        SAMPLER_EN = 1'b1;
        COUNTER_EN = 1'b1;
        RX_IN      = 1'b1;
        tick(6);
        RX_IN = 1'b0; tick(1);
        RX_IN = 1'b1; tick(1);
        chk("vote010_before", SAMPLED_BIT, 1);
        RX_IN = 1'b0; tick(1);
        chk("vote010_edge", EDGE_COUNT, 9);
        chk("vote010", SAMPLED_BIT, 0);
        RX_IN = 1'b1; tick(13);
        RX_IN = 1'b1; tick(1);
        RX_IN = 1'b0; tick(1);
        RX_IN = 1'b1; tick(1);
        chk("vote101", SAMPLED_BIT, 1);
        RX_IN = 1'b1; tick(13);
        RX_IN = 1'b0; tick(2);
        SAMPLER_EN = 1'b0;
        tick(1);
        SAMPLER_EN = 1'b1;
        chk("sampler_off_edge", EDGE_COUNT, 9);
        chk("sampler_off_hold", SAMPLED_BIT, 1);

        // Full 0xA5 frame at 32x with deserializer strobes at edge 17.
        PRESCALE   = 6'd32;
        COUNTER_EN = 1'b0;
        clear_counters();
        COUNTER_EN = 1'b1;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int b = 0; b < 10; b++) begin
            for (int e = 0; e < 32; e++) begin
                RX_IN           = frame[b];
                DESERIALIZER_EN = (b >= 1 && b <= 8 && e == 17);
                if (e == 17 && b == 1) chk("byte_first_sampled", SAMPLED_BIT, 1);
                if (e == 17 && b == 8) chk("byte_bit7_count", BIT_COUNT, 8);
                if (e == 17 && b == 8) chk("byte_bit7_edge", EDGE_COUNT, 17);
                tick(1);
                if (e == 17 && b == 1) chk("byte_first_shift", P_DATA, 8'h80);
            end
        end
        DESERIALIZER_EN = 1'b0;
        chk("byte_pdata", P_DATA, 8'hA5);
        chk("byte_end_bit", BIT_COUNT, 10);
        COUNT_RST       = 1'b0;
        DESERIALIZER_EN = 1'b1;
        tick(1);
        COUNT_RST       = 1'b1;
        DESERIALIZER_EN = 1'b0;
        chk("clear_and_shift_pdata", P_DATA, 8'hD2);
        chk("clear_and_shift_edge", EDGE_COUNT, 0);
        chk("clear_and_shift_bit", BIT_COUNT, 0);

        // Illegal prescale 12 behaves as 8.
        PRESCALE = 6'd12;
        RX_IN    = 1'b1;
        tick(7);
        chk("p12_edge7", EDGE_COUNT, 7);
        tick(1);
        chk("p12_wrap_edge", EDGE_COUNT, 0);
        chk("p12_wrap_bit", BIT_COUNT, 1);
        for (int e = 0; e < 5; e++) begin
            RX_IN = (e == 2 || e == 3) ? 1'b0 : 1'b1;
            tick(1);
        end
        chk("p12_vote", SAMPLED_BIT, 0);
        chk("p12_vote_edge", EDGE_COUNT, 5);

        // Counter hold at edge 5, then a hold at the vote edge.
        PRESCALE   = 6'd8;
        COUNTER_EN = 1'b0;
        clear_counters();
        COUNTER_EN = 1'b1;
        RX_IN      = 1'b1;
        tick(5);
        chk("hold_pre_sampled", SAMPLED_BIT, 1);
        COUNTER_EN = 1'b0;
        RX_IN      = 1'b0;
        tick(20);
        chk("hold_edge", EDGE_COUNT, 5);
        chk("hold_bit", BIT_COUNT, 0);
        chk("hold_sampled", SAMPLED_BIT, 1);
        COUNTER_EN = 1'b1;
        RX_IN      = 1'b1;
        tick(5);
        RX_IN = 1'b0;
        tick(2);
        COUNTER_EN = 1'b0;
        RX_IN      = 1'b1;
        tick(20);
        chk("hold_vote_edge", EDGE_COUNT, 4);
        chk("hold_vote_sampled", SAMPLED_BIT, 1);
        COUNTER_EN = 1'b1;
        tick(1);
        chk("resume_vote_edge", EDGE_COUNT, 5);
        chk("resume_vote_sampled", SAMPLED_BIT, 0);
        chk("resume_vote_bit", BIT_COUNT, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_edge_sampler.md
# uart_rx_edge_sampler

Oversampling timebase and bit recovery stage for the UART receiver. Counts CLK edges within each bit period (EDGE_COUNT), counts completed bit periods (BIT_COUNT), recovers each bit by 3-sample majority vote around mid-bit, and shifts recovered data bits LSB-first into an 8-bit parallel register. Driven by the RX control FSM, which consumes EDGE_COUNT, BIT_COUNT and SAMPLED_BIT and supplies the enable and clear strobes. RX_IN is already synchronous to CLK; this block contains no synchronizer.

## Interface
- No parameters; frame width fixed at 8 data bits, counter widths fixed.
- CLK  in  1  receiver oversampling clock.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line, idle high, synchronous to CLK.
- PRESCALE  in  6  oversampling ratio; legal 8, 16, 32; any other value behaves as 8.
- COUNTER_EN  in  1  advance edge/bit counters this cycle.
- COUNT_RST  in  1  synchronous active-low clear of both counters; priority over COUNTER_EN.
- SAMPLER_EN  in  1  permits SAMPLED_BIT update.
- DESERIALIZER_EN  in  1  shift SAMPLED_BIT into P_DATA this cycle.
- EDGE_COUNT  out  5  position within current bit period, 0..PRESCALE-1.
- BIT_COUNT  out  4  completed bit periods since last clear.
- SAMPLED_BIT  out  1  majority-voted value of the most recent sampled bit.
- P_DATA  out  8  deserialized data, first received bit in P_DATA[0] after 8 shifts.

## Operation
- Effective prescale P = PRESCALE if in {8,16,32}, else 8. First-sample index FS = P/2 − 2 (8→2, 16→6, 32→14).
- Counters (registered, evaluated each CLK rising edge, in priority order):
  - COUNT_RST=0: EDGE_COUNT←0, BIT_COUNT←0.
  - COUNTER_EN=1 and EDGE_COUNT==P−1: EDGE_COUNT←0, BIT_COUNT←BIT_COUNT+1 (4-bit modulo, 15 wraps to 0).
  - COUNTER_EN=1 otherwise: EDGE_COUNT←EDGE_COUNT+1.
  - COUNTER_EN=0: both hold.
- EDGE_COUNT above P−1 (possible only when PRESCALE changes mid-frame): next enabled cycle wraps EDGE_COUNT to 0 and increments BIT_COUNT, the same as the P−1 case. PRESCALE must be static during a frame; no other recovery is defined.
- Sampler: 2-entry sample register S0/S1.
  - COUNTER_EN=1 and EDGE_COUNT==FS: S0←RX_IN.
  - COUNTER_EN=1 and EDGE_COUNT==FS+1: S1←RX_IN.
  - COUNTER_EN=1, SAMPLER_EN=1 and EDGE_COUNT==FS+2: SAMPLED_BIT←majority(S0, S1, RX_IN).
  - SAMPLED_BIT holds at all other times, including when SAMPLER_EN=0 at FS+2.
- Deserializer: DESERIALIZER_EN=1 at a clock edge → P_DATA←{SAMPLED_BIT, P_DATA[7:1]}. No clear other than reset; each frame overwrites P_DATA through 8 shifts.
- Simultaneous COUNT_RST=0 and DESERIALIZER_EN=1: both take effect (counter clear and shift are independent).
- There is no FSM in this block; all behaviour is counter- and strobe-driven.

## Timing
- Reset values: EDGE_COUNT=0, BIT_COUNT=0, SAMPLED_BIT=1, P_DATA=8'h00, S0=S1=1.
- An assertion of RST at any point, including mid-frame, returns all registers to their reset values immediately (asynchronous). Operation resumes on the first CLK edge after release.
- All outputs are registered, with no combinational path from input to output.
- SAMPLED_BIT for a bit is valid from the cycle where EDGE_COUNT==FS+3. The FSM's check or deserializer strobe issued in that cycle sees the new value.
- Bit period is exactly P enabled cycles. BIT_COUNT increments in the cycle after EDGE_COUNT==P−1.
- For a frame started with a cleared counter: BIT_COUNT=1 during data bit 0, and BIT_COUNT=8 during data bit 7.

## Test plan
- Reset mid-count: PRESCALE=16, run to EDGE_COUNT=9, BIT_COUNT=3, then pulse RST low → all outputs at reset values; after release with COUNTER_EN=1, EDGE_COUNT counts 0,1,2,…
- Wrap and bit count: PRESCALE=8, COUNTER_EN=1 for 8×10 cycles → EDGE_COUNT cycles 0..7. BIT_COUNT reaches 10, and 16 periods wrap it to 0. COUNT_RST=0 together with COUNTER_EN=1 gives 0/0 on the next cycle.
- Majority vote: PRESCALE=16, RX_IN=0,1,0 at EDGE 6,7,8 with SAMPLER_EN=1 → SAMPLED_BIT=0 at EDGE 9. Repeat with 1,0,1 → 1. SAMPLER_EN=0 at EDGE 8 → SAMPLED_BIT unchanged.
- Full byte: PRESCALE=32, drive frame start(0), data 8'hA5 LSB-first, stop(1), with FSM-equivalent strobes (DESERIALIZER_EN at EDGE 17 of each data bit) → P_DATA=8'hA5 after the 8th shift. BIT_COUNT=8 during the last data bit.
- Illegal prescale: PRESCALE=12 → EDGE_COUNT wraps at 7 and sampling occurs at EDGE 2,3,4, identical to PRESCALE=8.
- Counter hold: COUNTER_EN=0 for 20 cycles at EDGE_COUNT=5 → EDGE_COUNT, BIT_COUNT and S0/S1 unchanged, and no SAMPLED_BIT update.
